// File: rtl/math_unit_seq.sv
// math_unit_seq: registered ADD/SUB/ADC plus iterative shift-add MULU with start/done handshake and held flags.
module math_unit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             busy,
  output logic             cout,
  output logic             overflow,
  output logic             neg,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic done_q, done_d, cout_q, cout_d, ovf_q, ovf_d, neg_q, neg_d, zero_q, zero_d;
  logic accept, last, cin;
  logic [WIDTH-1:0] bx, prod_lo;
  logic [WIDTH:0] sum, step;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    accept = start && (state_q == IDLE);
    last = (state_q == MUL) && (cnt_q == CW'(1));
    state_d = (state_q == IDLE) ? ((accept && op == 2'b11) ? MUL : IDLE) : (last ? IDLE : MUL);
  end
  always_comb begin
    bx = (op == 2'b01) ? ~b : b;
    cin = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? cout_q : 1'b0;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    // one shift-add step: conditional add into the upper half, then shift {carry,acc,mplier} right
    step = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_lo = {step[0], mplier_q[WIDTH-1:1]};
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    result_d = result_q;
    result_hi_d = result_hi_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    neg_d = neg_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (accept && op != 2'b11) begin
      result_d = sum[WIDTH-1:0];
      result_hi_d = '0;
      cout_d = sum[WIDTH];
      ovf_d = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      neg_d = sum[WIDTH-1];
      zero_d = (sum[WIDTH-1:0] == '0);
      done_d = 1'b1;
    end else if (accept) begin
      mcand_d = a;
      mplier_d = b;
      acc_d = '0;
      cnt_d = CW'(WIDTH);
    end
    if (state_q == MUL) begin
      acc_d = step[WIDTH:1];
      mplier_d = prod_lo;
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        result_d = prod_lo;
        result_hi_d = step[WIDTH:1];
        cout_d = |step[WIDTH:1];
        ovf_d = |step[WIDTH:1];
        neg_d = prod_lo[WIDTH-1];
        zero_d = (prod_lo == '0);
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      result_hi_q <= '0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      neg_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      done_q <= done_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      neg_q <= neg_d;
      zero_q <= zero_d;
    end
  end
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign done = done_q;
  assign busy = (state_q == MUL);
  assign cout = cout_q;
  assign overflow = ovf_q;
  assign neg = neg_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_math_unit_seq.sv
// tb_math_unit_seq: directed vectors with hand-computed expectations for math_unit_seq (WIDTH=16).
module tb_math_unit_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [15:0] a = '0, b = '0, result, result_hi;
  logic done, busy, cout, overflow, neg, zero;
  int errors = 0, checks = 0;
  math_unit_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .done(done), .busy(busy),
    .cout(cout), .overflow(overflow), .neg(neg), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // packed as {hi, lo, done, busy, cout, overflow, neg, zero}
  task automatic chk_all(input string tag, input logic [15:0] hi, input logic [15:0] lo,
                         input logic dn, input logic bz, input logic c, input logic v,
                         input logic n, input logic z);
    chk(tag, {26'd0, result_hi, result, done, busy, cout, overflow, neg, zero},
        {26'd0, hi, lo, dn, bz, c, v, n, z});
  endtask
  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  initial begin
    int n, dones;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset_idle", 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    issue(2'b00, 16'h7FFF, 16'h0001);
    chk_all("add_ovf", 16'h0000, 16'h8000, 1, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    chk_all("add_done_once", 16'h0000, 16'h8000, 0, 0, 0, 1, 1, 0);
    issue(2'b01, 16'h0005, 16'h0005);
    chk_all("sub_zero", 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 1);
    issue(2'b10, 16'hFFFF, 16'h0000);
    chk_all("adc_carry_in", 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 1);
    issue(2'b10, 16'h0001, 16'h0001);
    chk_all("adc_chain", 16'h0000, 16'h0003, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("hold_after_adc", 16'h0000, 16'h0003, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(2'b11, 16'h1234, 16'h0100);
    chk_all("mul_start", 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 2'b00; a = 16'h0001; b = 16'h0001;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("mul_busy_%0d", k), {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    chk_all("mul_1234x0100", 16'h0012, 16'h3400, 1, 0, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk_all("mul_no_extra_done", 16'h0012, 16'h3400, 0, 0, 1, 1, 0, 0);
    issue(2'b11, 16'hFFFF, 16'hFFFF);
    wait_done(n);
    chk("mul_ffff_latency", 64'(n), 64'd16);
    chk_all("mul_ffffxffff", 16'hFFFE, 16'h0001, 1, 0, 1, 1, 0, 0);
    @(posedge clk); #1;
    issue(2'b11, 16'h0000, 16'hABCD);
    wait_done(n);
    chk("mul_zero_latency", 64'(n), 64'd16);
    chk_all("mul_0xabcd", 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    issue(2'b11, 16'h00FF, 16'h00FF);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1 chk_all("mul_abort", 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      dones += int'(done) + int'(busy);
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    issue(2'b00, 16'h0002, 16'h0003);
    chk_all("add_after_abort", 16'h0000, 16'h0005, 1, 0, 0, 0, 0, 0);
    issue(2'b11, 16'h0003, 16'h0004);
    chk("mul_in_done_cycle", {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
    wait_done(n);
    chk("mul_3x4_latency", 64'(n), 64'd16);
    chk_all("mul_3x4", 16'h0000, 16'h000C, 1, 0, 0, 0, 0, 0);
    issue(2'b00, 16'h0010, 16'h0020);
    chk_all("add_in_mul_done_cycle", 16'h0000, 16'h0030, 1, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/math_unit_seq.md
# math_unit_seq

Parametrised, registered successor to the combinational 16-bit add/sub unit, with a start/done handshake. It performs ADD, SUB, add-with-carry (ADC) and unsigned multiply (MULU) on WIDTH-bit operands. ADD, SUB and ADC complete in one cycle. MULU is an iterative shift-add taking WIDTH cycles and returns a 2×WIDTH product. Status flags (carry, overflow, negative, zero) are held in registers, which allows multi-word arithmetic through ADC.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits (legal range ≥4).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- op  input  2  00=ADD, 01=SUB, 10=ADC, 11=MULU.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- result  output  WIDTH  result, or low half of the product.
- result_hi  output  WIDTH  high half of the product; 0 for ADD/SUB/ADC.
- done  output  1  one-cycle pulse: result and flags updated.
- busy  output  1  high while MULU is iterating.
- cout  output  1  carry flag (registered).
- overflow  output  1  signed-overflow flag (registered).
- neg  output  1  equals result[WIDTH-1] (registered).
- zero  output  1  high when result == 0 (registered).

## Operation

- FSM states:
  - IDLE → MUL when start=1 and op=MULU.
  - MUL → IDLE when the iteration counter reaches 0.
  - ADD/SUB/ADC stay in IDLE.
- Reset (async): state=IDLE. result, result_hi, done, busy, cout, overflow, neg and zero are all 0. Iteration counter is 0.
- ADD: {cout,result} = a + b.
- SUB: {cout,result} = a + ~b + 1. cout=1 means no borrow.
- ADC: {cout,result} = a + b + cout_reg, where cout_reg is the flag value before the operation.
- Overflow for ADD/SUB/ADC: a[MSB] equals b'[MSB] and result[MSB] differs from it. b' is b for ADD/ADC and ~b for SUB.
- MULU:
  - On start, load multiplicand=a, multiplier=b, accumulator=0, counter=WIDTH.
  - Each MUL cycle: if multiplier[0]=1, add the multiplicand into the upper half of the accumulator. Then shift {carry,accumulator,multiplier} right by one and decrement the counter.
  - On completion, {result_hi,result} = a×b (unsigned, exact).
  - cout = overflow = |result_hi (product does not fit in WIDTH bits).
  - neg = result[WIDTH-1]; zero = (result == 0).
- Flags update only together with done. Between operations they hold their values.
- start while busy=1 is ignored: operands are not recaptured and no extra done is produced.
- result and result_hi hold their value until the next done. Intermediate multiplier state never appears on result or result_hi.
- Reset mid-MUL aborts the operation: no done, and all outputs go to their reset values.

## Timing

- ADD/SUB/ADC: start accepted at edge E0. result, flags and done=1 are visible after E0. Latency 1 cycle, throughput 1 op per cycle.
- MULU: start accepted at E0. busy=1 from after E0 through edge E(WIDTH-1). At E(WIDTH), busy=0, done=1 and results/flags are written. Latency WIDTH cycles.
- done is high for exactly one cycle per accepted start.
- A start presented in the cycle where done=1 (state IDLE) is accepted. Back-to-back operations therefore have no bubble.
- ADC chained directly after an op uses the cout written at that op's done edge.
- Operands a, b and op need to be valid only in the start cycle.

## Test plan

1. Reset released, then no stimulus → result=0, result_hi=0, every flag 0, done=0, busy=0. Assert rst asynchronously (no clk edge) while outputs are nonzero → all outputs clear immediately.
2. WIDTH=16, ADD a=0x7FFF b=0x0001 → one cycle later: result=0x8000, overflow=1, neg=1, cout=0, zero=0, done pulses once.
3. SUB 0x0005−0x0005 → result=0x0000, zero=1, cout=1. Next cycle, ADC a=0xFFFF b=0x0000 → result=0x0000, cout=1, zero=1. Then ADC 0x0001+0x0001 → result=0x0003, cout=0.
4. MULU 0x1234×0x0100 → busy high for 16 cycles, done at cycle 16, result=0x3400, result_hi=0x0012, cout=overflow=1. A start (ADD) pulsed at cycle 5 is ignored.
5. MULU 0xFFFF×0xFFFF → result=0x0001, result_hi=0xFFFE, cout=1, overflow=1, neg=0. Then MULU 0x0000×0xABCD → result=0, result_hi=0, zero=1, cout=0.
6. rst pulsed at cycle 8 of a MULU → busy=0, no done, all outputs 0. A following ADD 0x0002+0x0003 gives result=0x0005 after 1 cycle. A second start issued in the done cycle is accepted with no gap.
